alu_decoder: RTL and testbench



---
 rtl/alu_decoder.sv | 152 +++++++++++++++
 tb/tb_alu_decoder.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
//
// Command decoder for the data-processing path of the single-cycle ARM-subset
// CPU controller. It takes the main decoder's alu_op, the instruction S bit and
// the 4-bit cmd field. From these it selects:
//   - the ALU operation,
//   - the N/Z and C/V flag-write enables,
//   - a flag for compare/test instructions, which do not write a register,
//   - a flag for shift/MOV instructions, which use the shifter result.
//
// Compile-time option:
//   ALU_DECODER_REG_OUT_EN
//     Defined   : all outputs are registered on posedge clk, giving a latency
//                 of 1 cycle. reset_n (async, active-low) clears them to 0.
//     Undefined : outputs are purely combinational. clk and reset_n are
//                 present but unused.
//
// Ports:
//   clk       in  1  clock (only used with the output register)
//   reset_n   in  1  asynchronous active-low reset (only used with the register)
//   alu_op    in  1  1 = data-processing instruction, decode cmd
//                    0 = ADD without flag update
//   s         in  1  instruction S bit (set flags)
//   cmd       in  4  instruction cmd field, bits [24:21]
//   alu_ctl   out 3  ALU operation select
//   flag_w    out 2  flag write enables: [1] = N,Z ; [0] = C,V
//   no_write  out 1  suppress register-file write (CMP/CMN/TST)
//   shift     out 1  result comes from the shifter path (LSL/LSR/MOV)
// -----------------------------------------------------------------------------
module alu_decoder (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       alu_op,
    input  logic       s,
    input  logic [3:0] cmd,
    output logic [2:0] alu_ctl,
    output logic [1:0] flag_w,
    output logic       no_write,
    output logic       shift
);

    logic [2:0] w_alu_ctl;
    logic [1:0] w_flag_w;
    logic       w_no_write;
    logic       w_shift;

    // Arithmetic ops update all four flags; logic ops update only N,Z.
    logic [1:0] w_fw_arith;
    logic [1:0] w_fw_logic;
    assign w_fw_arith = {s, s};
    assign w_fw_logic = {s, 1'b0};

    always_comb begin
        w_alu_ctl  = 3'b000;
        w_flag_w   = 2'b00;
        w_no_write = 1'b0;
        w_shift    = 1'b0;
        if (alu_op) begin
            case (cmd)
                4'b0100: begin                  // ADD
                    w_alu_ctl = 3'b000;
                    w_flag_w  = w_fw_arith;
                end
                4'b0010: begin                  // SUB
                    w_alu_ctl = 3'b001;
                    w_flag_w  = w_fw_arith;
                end
                4'b0000: begin                  // AND
                    w_alu_ctl = 3'b010;
                    w_flag_w  = w_fw_logic;
                end
                4'b1100: begin                  // ORR
                    w_alu_ctl = 3'b011;
                    w_flag_w  = w_fw_logic;
                end
                4'b0001: begin                  // EOR
                    w_alu_ctl = 3'b110;
                    w_flag_w  = w_fw_logic;
                end
                4'b0101: begin                  // ADC
                    w_alu_ctl = 3'b100;
                    w_flag_w  = w_fw_arith;
                end
                4'b1010: begin                  // CMP: subtract, flags only
                    w_alu_ctl  = 3'b001;
                    w_flag_w   = w_fw_arith;
                    w_no_write = 1'b1;
                end
                4'b1011: begin                  // CMN: add, flags only
                    w_alu_ctl  = 3'b000;
                    w_flag_w   = w_fw_arith;
                    w_no_write = 1'b1;
                end
                4'b1000: begin                  // TST: AND, flags only
                    w_alu_ctl  = 3'b010;
                    w_flag_w   = w_fw_logic;
                    w_no_write = 1'b1;
                end
                4'b1101: begin                  // LSL/LSR/MOV via shifter
                    // The ALU result is bypassed here, so the low select bits
                    // are left free for the synthesiser to optimise.
                    w_alu_ctl = 3'b0xx;
                    w_flag_w  = w_fw_logic;
                    w_shift   = 1'b1;
                end
                default: begin                  // unsupported: all zero
                    w_alu_ctl  = 3'b000;
                    w_flag_w   = 2'b00;
                    w_no_write = 1'b0;
                    w_shift    = 1'b0;
                end
            endcase
        end
    end

`ifdef ALU_DECODER_REG_OUT_EN
    logic [2:0] r_alu_ctl;
    logic [1:0] r_flag_w;
    logic       r_no_write;
    logic       r_shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alu_ctl  <= 3'b000;
            r_flag_w   <= 2'b00;
            r_no_write <= 1'b0;
            r_shift    <= 1'b0;
        end else begin
            r_alu_ctl  <= w_alu_ctl;
            r_flag_w   <= w_flag_w;
            r_no_write <= w_no_write;
            r_shift    <= w_shift;
        end
    end

    assign alu_ctl  = r_alu_ctl;
    assign flag_w   = r_flag_w;
    assign no_write = r_no_write;
    assign shift    = r_shift;
`else
    // clk and reset_n are kept so both builds have the same port list.
    logic w_unused;
    assign w_unused = &{1'b0, clk, reset_n};

    assign alu_ctl  = w_alu_ctl;
    assign flag_w   = w_flag_w;
    assign no_write = w_no_write;
    assign shift    = w_shift;
`endif

endmodule

// File: tb/tb_alu_decoder.sv
// -----------------------------------------------------------------------------
// tb_alu_decoder: self-checking bench for alu_decoder (either build).
//
// Expected outputs come from a table-driven reference model. The model records
// each cmd's operation class and ALU code.
// Observed outputs are packed as {alu_ctl, flag_w, no_write, shift}.
// For the shifter command, the don't-care alu_ctl[1:0] bits are masked out.
// -----------------------------------------------------------------------------
module tb_alu_decoder;

    logic       clk;
    logic       reset_n;
    logic       alu_op;
    logic       s;
    logic [3:0] cmd;
    logic [2:0] alu_ctl;
    logic [1:0] flag_w;
    logic       no_write;
    logic       shift;

    int checks   = 0;
    int failures = 0;

    alu_decoder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .alu_op   (alu_op),
        .s        (s),
        .cmd      (cmd),
        .alu_ctl  (alu_ctl),
        .flag_w   (flag_w),
        .no_write (no_write),
        .shift    (shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Operation classes:
    //   0 = unsupported
    //   1 = arithmetic (flags 11 when S=1)
    //   2 = logic      (flags 10 when S=1)
    //   3 = shifter    (flags 10 when S=1)
    int ctl_tab [16];
    int cls_tab [16];
    int nw_tab  [16];

    task automatic init_tables();
        for (int i = 0; i < 16; i++) begin
            ctl_tab[i] = 0;
            cls_tab[i] = 0;
            nw_tab[i]  = 0;
        end
        ctl_tab[4]  = 0; cls_tab[4]  = 1;                 // ADD
        ctl_tab[2]  = 1; cls_tab[2]  = 1;                 // SUB
        ctl_tab[0]  = 2; cls_tab[0]  = 2;                 // AND
        ctl_tab[12] = 3; cls_tab[12] = 2;                 // ORR
        ctl_tab[1]  = 6; cls_tab[1]  = 2;                 // EOR
        ctl_tab[5]  = 4; cls_tab[5]  = 1;                 // ADC
        ctl_tab[10] = 1; cls_tab[10] = 1; nw_tab[10] = 1; // CMP
        ctl_tab[11] = 0; cls_tab[11] = 1; nw_tab[11] = 1; // CMN
        ctl_tab[8]  = 2; cls_tab[8]  = 2; nw_tab[8]  = 1; // TST
        ctl_tab[13] = 0; cls_tab[13] = 3;                 // LSL/LSR/MOV
    endtask

    // Returns the expected packed vector and a mask of the bits to compare.
    task automatic model(input logic op, input logic sv, input logic [3:0] c,
                         output logic [6:0] e, output logic [6:0] m);
        int ctl, fw, nw, sh, cls;
        m  = 7'b1111111;
        ctl = 0; fw = 0; nw = 0; sh = 0;
        if (op) begin
            cls = cls_tab[c];
            ctl = ctl_tab[c];
            nw  = nw_tab[c];
            sh  = (cls == 3) ? 1 : 0;
            if (sv && cls == 1) fw = 3;
            else if (sv && cls >= 2) fw = 2;
            if (cls == 3) m = 7'b1001111;
        end
        e = {ctl[2:0], fw[1:0], nw[0], sh[0]};
    endtask

    // Drives one decode and waits until its result is visible at the outputs.
    task automatic apply(input logic op, input logic sv, input logic [3:0] c);
        @(negedge clk);
        alu_op = op;
        s      = sv;
        cmd    = c;
`ifdef ALU_DECODER_REG_OUT_EN
        @(posedge clk);
        #1;
`else
        #1;
`endif
    endtask

    function automatic logic [6:0] obs();
        return {alu_ctl, flag_w, no_write, shift};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [6:0] e, m;
        alu_op  = 1'b1;
        s       = 1'b1;
        cmd     = 4'b0100;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`ifdef ALU_DECODER_REG_OUT_EN
        checks++;
        if (obs() !== 7'b0) begin
            failures++;
            $display("FAIL reset_hold: got %b want %b", obs(), 7'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs() !== 7'b0) begin
            failures++;
            $display("FAIL reset_release_before_edge: got %b want %b", obs(), 7'b0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (flag_w !== 2'b11 || obs() !== 7'b0001100) begin
            failures++;
            $display("FAIL reset_first_decode: got %b want %b", obs(), 7'b0001100);
        end
`else
        // Combinational build: reset has no effect on the outputs.
        model(1'b1, 1'b1, 4'b0100, e, m);
        checks++;
        if ((obs() & m) !== e) begin
            failures++;
            $display("FAIL reset_no_effect: got %b want %b", obs(), e);
        end
        reset_n = 1'b1;
`endif
        $display("test_reset done");
    endtask

    task automatic test_alu_op_zero();
        logic [6:0] e, m;
        apply(1'b0, 1'b1, 4'b0100);
        checks++;
        if (obs() !== 7'b0) begin
            failures++;
            $display("FAIL alu_op0_add_s1: got %b want %b", obs(), 7'b0);
        end
        for (int i = 0; i < 8; i++) begin
            apply(1'b0, 1'($urandom_range(1)), 4'($urandom_range(15)));
            model(alu_op, s, cmd, e, m);
            checks++;
            if ((obs() & m) !== e) begin
                failures++;
                $display("FAIL alu_op0 s=%b cmd=%b: got %b want %b", s, cmd, obs(), e);
            end
        end
    endtask

    task automatic test_arith();
        logic [3:0] cmds [3];
        logic [6:0] e, m;
        cmds = '{4'b0100, 4'b0010, 4'b0101};
        for (int i = 0; i < 3; i++) begin
            for (int sv = 0; sv < 2; sv++) begin
                apply(1'b1, 1'(sv), cmds[i]);
                model(1'b1, 1'(sv), cmds[i], e, m);
                checks++;
                if ((obs() & m) !== e) begin
                    failures++;
                    $display("FAIL arith cmd=%b s=%0d: got %b want %b", cmds[i], sv, obs(), e);
                end
            end
        end
    endtask

    task automatic test_logic();
        logic [3:0] cmds [3];
        logic [6:0] e, m;
        cmds = '{4'b0000, 4'b1100, 4'b0001};
        for (int i = 0; i < 3; i++) begin
            for (int sv = 0; sv < 2; sv++) begin
                apply(1'b1, 1'(sv), cmds[i]);
                model(1'b1, 1'(sv), cmds[i], e, m);
                checks++;
                if ((obs() & m) !== e) begin
                    failures++;
                    $display("FAIL logic cmd=%b s=%0d: got %b want %b", cmds[i], sv, obs(), e);
                end
            end
        end
    endtask

    task automatic test_compare();
        logic [3:0] cmds [3];
        logic [6:0] want [3];
        cmds = '{4'b1010, 4'b1011, 4'b1000};
        want = '{7'b0011110, 7'b0001110, 7'b0101010};
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b1, cmds[i]);
            checks++;
            if (obs() !== want[i]) begin
                failures++;
                $display("FAIL compare cmd=%b: got %b want %b", cmds[i], obs(), want[i]);
            end
        end
    endtask

    task automatic test_shift();
        for (int sv = 0; sv < 2; sv++) begin
            apply(1'b1, 1'(sv), 4'b1101);
            checks++;
            if (alu_ctl[2] !== 1'b0 || flag_w !== (sv == 1 ? 2'b10 : 2'b00) ||
                no_write !== 1'b0 || shift !== 1'b1) begin
                failures++;
                $display("FAIL shift s=%0d: got ctl=%b fw=%b nw=%b sh=%b want ctl=0xx fw=%s nw=0 sh=1",
                         sv, alu_ctl, flag_w, no_write, shift, (sv == 1) ? "10" : "00");
            end
        end
    endtask

    task automatic test_unsupported();
        logic [3:0] cmds [6];
        cmds = '{4'b0011, 4'b0110, 4'b0111, 4'b1001, 4'b1110, 4'b1111};
        for (int i = 0; i < 6; i++) begin
            apply(1'b1, 1'b1, cmds[i]);
            checks++;
            if (obs() !== 7'b0) begin
                failures++;
                $display("FAIL unsupported cmd=%b: got %b want %b", cmds[i], obs(), 7'b0);
            end
        end
    endtask

    // One new random decode per cycle.
    task automatic test_back_to_back();
        logic [6:0] e, m;
        for (int i = 0; i < 200; i++) begin
            apply(1'($urandom_range(3) != 0), 1'($urandom_range(1)), 4'($urandom_range(15)));
            model(alu_op, s, cmd, e, m);
            checks++;
            if ((obs() & m) !== e || (no_write === 1'b1 && shift === 1'b1)) begin
                failures++;
                $display("FAIL random op=%b s=%b cmd=%b: got %b want %b", alu_op, s, cmd, obs(), e);
            end
        end
    endtask

    task automatic test_midcycle_reset();
`ifdef ALU_DECODER_REG_OUT_EN
        apply(1'b1, 1'b1, 4'b0100);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 7'b0) begin
            failures++;
            $display("FAIL midcycle_reset: got %b want %b", obs(), 7'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (obs() !== 7'b0001100) begin
            failures++;
            $display("FAIL decode_after_reset: got %b want %b", obs(), 7'b0001100);
        end
`else
        // Combinational build: outputs follow the inputs with no clock edge.
        @(negedge clk);
        #1;
        alu_op = 1'b1;
        s      = 1'b1;
        cmd    = 4'b0010;
        #1;
        checks++;
        if (obs() !== 7'b0011100) begin
            failures++;
            $display("FAIL comb_no_clock: got %b want %b", obs(), 7'b0011100);
        end
`endif
    endtask

    initial begin
        alu_op  = 1'b0;
        s       = 1'b0;
        cmd     = 4'b0000;
        reset_n = 1'b0;
        init_tables();
        test_reset();
        test_alu_op_zero();
        test_arith();
        test_logic();
        test_compare();
        test_shift();
        test_unsupported();
        test_back_to_back();
        test_midcycle_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
